pong_input_ctrl: RTL



---
 rtl/pong_input_ctrl_if.sv | 25 ++
 rtl/pong_input_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pong_input_ctrl_if.sv
// Control bus between the button front end and the paddle controllers.
// The master modport is the producing end (pong_input_ctrl).
interface pong_input_ctrl_if;
  logic       btn_p1_up_n;
  logic       btn_p1_down_n;
  logic       btn_p2_up_n;
  logic       btn_p2_down_n;
  logic       game_over;
  logic       p1_move_up;
  logic       p1_move_down;
  logic       p2_move_up;
  logic       p2_move_down;
  logic [1:0] mode_choice;
  logic       reset_game;

  modport master (
    input  btn_p1_up_n, btn_p1_down_n, btn_p2_up_n, btn_p2_down_n, game_over,
    output p1_move_up, p1_move_down, p2_move_up, p2_move_down, mode_choice, reset_game
  );

  modport slave (
    output btn_p1_up_n, btn_p1_down_n, btn_p2_up_n, btn_p2_down_n, game_over,
    input  p1_move_up, p1_move_down, p2_move_up, p2_move_down, mode_choice, reset_game
  );
endinterface

// File: rtl/pong_input_ctrl.sv
// Pong button front end: per-button sync + debounce lanes feeding the
// game-mode menu FSM that drives mode_choice, reset_game and paddle moves.

module pong_btn_db #(
  parameter int DB_CYCLES = 8
) (
  input  logic clk_0,
  input  logic rst,
  input  logic btn_n_i,
  output logic stable_o,
  output logic rise_o
);
  localparam logic [17:0] DB_LAST = 18'(DB_CYCLES - 1);

  logic [1:0]  sync_q, prime_q;
  logic [17:0] cnt_q;
  logic        stable_q, rise_q, live_q;

  // live_q blocks a press edge until the lane has been seen released after
  // reset, so a button held through reset cannot make a menu selection.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      prime_q  <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], ~btn_n_i};
      prime_q <= {prime_q[0], 1'b1};
      if (prime_q[1] && !sync_q[1]) live_q <= 1'b1;
      rise_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        rise_q   <= sync_q[1] & live_q;
      end else begin
        cnt_q <= cnt_q + 18'd1;
      end
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
endmodule

module pong_input_ctrl #(
  parameter int CLK_HZ    = 25_175_000,
  parameter int DB_CYCLES = CLK_HZ / 100
) (
  input  logic                     clk_0,
  input  logic                     rst,
  pong_input_ctrl_if.master        ctl
);
  localparam int NUM_BTN = 4;

  typedef enum logic [1:0] {S_MENU, S_ARM, S_PLAY} state_e;

  // lane order: 0 p1_up, 1 p1_down, 2 p2_up, 3 p2_down
  logic [NUM_BTN-1:0] btn_n, stable, rise;
  assign btn_n = {ctl.btn_p2_down_n, ctl.btn_p2_up_n, ctl.btn_p1_down_n, ctl.btn_p1_up_n};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    pong_btn_db #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_0    (clk_0),
      .rst      (rst),
      .btn_n_i  (btn_n[g]),
      .stable_o (stable[g]),
      .rise_o   (rise[g])
    );
  end

  state_e             state_q;
  logic [1:0]         mode_q;
  logic               rg_q;
  logic [NUM_BTN-1:0] mv_q;

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_q <= S_MENU;
      mode_q  <= 2'd0;
      rg_q    <= 1'b0;
      mv_q    <= '0;
    end else begin
      rg_q <= 1'b0;
      case (state_q)
        S_MENU: begin
          mv_q <= '0;
          // simultaneous p1 edges are ambiguous and rejected
          if (rise[0] ^ rise[1]) begin
            rg_q    <= 1'b1;
            mode_q  <= rise[0] ? 2'd1 : 2'd2;
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          mv_q <= '0;
          if (ctl.game_over) begin
            rg_q    <= 1'b1;
            mode_q  <= 2'd0;
            state_q <= S_MENU;
          end else if (stable == '0) begin
            state_q <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (ctl.game_over) begin
            rg_q    <= 1'b1;
            mode_q  <= 2'd0;
            mv_q    <= '0;
            state_q <= S_MENU;
          end else begin
            mv_q[1:0] <= stable[1:0];
            mv_q[3:2] <= (mode_q == 2'd2) ? stable[3:2] : 2'b00;
          end
        end
        default: begin
          mv_q    <= '0;
          mode_q  <= 2'd0;
          state_q <= S_MENU;
        end
      endcase
    end
  end

  assign ctl.p1_move_up   = mv_q[0];
  assign ctl.p1_move_down = mv_q[1];
  assign ctl.p2_move_up   = mv_q[2];
  assign ctl.p2_move_down = mv_q[3];
  assign ctl.mode_choice  = mode_q;
  assign ctl.reset_game   = rg_q;
endmodule
